// File: rtl/dmr_handshake_join.sv
// dmr_handshake_join: joins NUM_IN lock-stepped producer streams into one checked, registered stream
module dmr_handshake_join #(
  parameter type T = logic,
  parameter int NUM_IN = 2,
  parameter int CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                error_before_i,
  input  logic                error_after_i,
  output logic                error_o,
  input  logic                cnt_clear_i,
  output logic [CntWidth-1:0] err_cnt_o,
  input  logic [NUM_IN-1:0]   valid_i,
  output logic [NUM_IN-1:0]   ready_o,
  input  T [NUM_IN-1:0]       data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o
);
  logic full_q;
  T data_q;
  logic [CntWidth-1:0] cnt_q;
  logic all_v, any_v, match, accept, drain;
  assign all_v = &valid_i;
  assign any_v = |valid_i;
  always_comb begin
    match = all_v;
    for (int k = 1; k < NUM_IN; k++) match = match & (data_i[k] == data_i[0]);
  end
  assign error_o = enable_i & ~error_before_i & ((any_v & ~all_v) | (all_v & ~match));
  assign accept = ~full_q & (enable_i ? match & ~error_before_i : valid_i[0]);
  assign ready_o = enable_i ? {NUM_IN{accept}} : {{(NUM_IN-1){1'b0}}, ~full_q};
  // a consumer-side error keeps the entry so the same transaction is replayed
  assign drain = full_q & ready_i & ~(enable_i & error_after_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      data_q <= data_i[0];
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else if (cnt_clear_i) cnt_q <= '0;
    else if (error_o && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end
  assign valid_o = full_q;
  assign data_o = data_q;
  assign err_cnt_o = cnt_q;
endmodule

// File: tb/tb_dmr_handshake_join.sv
// tb_dmr_handshake_join: directed stimulus checked every cycle against a transaction-level model
module tb_dmr_handshake_join;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b1, eb = 1'b0, ea = 1'b0, clr = 1'b0, rdy_in = 1'b1;
  logic [1:0] valid = 2'b00;
  logic [1:0][7:0] data = '0;
  logic err, vo;
  logic [7:0] cnt, dout;
  logic [1:0] rdy;
  int n_cmp = 0, n_bad = 0;
  logic m_full;
  logic [7:0] m_data;
  int m_cnt;

  always #5 clk = ~clk;

  dmr_handshake_join #(.T(logic [7:0]), .NUM_IN(2), .CntWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .error_before_i(eb), .error_after_i(ea),
    .error_o(err), .cnt_clear_i(clr), .err_cnt_o(cnt), .valid_i(valid), .ready_o(rdy),
    .data_i(data), .valid_o(vo), .ready_i(rdy_in), .data_o(dout)
  );

  function automatic bit all_agree();
    return $countones(valid) == 2 && data[1] == data[0];
  endfunction
  function automatic bit exp_err();
    return en && !eb && $countones(valid) > 0 && !all_agree();
  endfunction
  function automatic bit exp_acc();
    return !m_full && (en ? (all_agree() && !eb) : valid[0]);
  endfunction
  function automatic logic [1:0] exp_rdy();
    return en ? (exp_acc() ? 2'b11 : 2'b00) : {1'b0, !m_full};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_cnt <= 0;
    end else begin
      if (exp_acc()) begin
        m_full <= 1'b1;
        m_data <= data[0];
      end else if (m_full && rdy_in && !(en && ea)) m_full <= 1'b0;
      m_cnt <= clr ? 0 : (exp_err() ? (m_cnt == 255 ? 255 : m_cnt + 1) : m_cnt);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid_o", {31'b0, vo}, {31'b0, m_full});
      chk("model_data_o", {24'b0, dout}, {24'b0, m_data});
      chk("model_ready_o", {30'b0, rdy}, {30'b0, exp_rdy()});
      chk("model_error_o", {31'b0, err}, {31'b0, exp_err()});
      chk("model_err_cnt_o", {24'b0, cnt}, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("reset_valid_o", {31'b0, vo}, 0);
    chk("reset_data_o", {24'b0, dout}, 0);
    chk("reset_err_cnt_o", {24'b0, cnt}, 0);
    chk("reset_error_o", {31'b0, err}, 0);
    #10 rst_n = 1'b1;
    step();
    // matching transfer
    valid = 2'b11; data = {8'hA5, 8'hA5}; #1;
    chk("t1_ready", {30'b0, rdy}, 2'b11);
    step(); valid = 2'b00; #1;
    chk("t1_valid_o", {31'b0, vo}, 1);
    chk("t1_data_o", {24'b0, dout}, 8'hA5);
    step(); #1;
    chk("t1_drained", {31'b0, vo}, 0);
    // data mismatch for 3 cycles
    valid = 2'b11; data = {8'hA4, 8'hA5};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_error_o", {31'b0, err}, 1);
      chk("t2_ready", {30'b0, rdy}, 2'b00);
      step();
    end
    data = {8'hA5, 8'hA5}; #1;
    chk("t2_cnt", {24'b0, cnt}, 3);
    chk("t2_ready_fix", {30'b0, rdy}, 2'b11);
    step(); valid = 2'b00; #1;
    chk("t2_data_o", {24'b0, dout}, 8'hA5);
    step();
    // valid skew
    valid = 2'b01; data = {8'h11, 8'h11};
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_error_o", {31'b0, err}, 1);
      chk("t3_ready", {30'b0, rdy}, 2'b00);
      step();
    end
    valid = 2'b11; #1;
    chk("t3_ready_ok", {30'b0, rdy}, 2'b11);
    chk("t3_cnt", {24'b0, cnt}, 5);
    step(); valid = 2'b00;
    step();
    // consumer-side error replays the transaction
    valid = 2'b11; data = {8'h5A, 8'h5A};
    step(); valid = 2'b00; ea = 1'b1; #1;
    chk("t4_valid_o", {31'b0, vo}, 1);
    step(); ea = 1'b0; #1;
    chk("t4_replay_valid", {31'b0, vo}, 1);
    chk("t4_replay_data", {24'b0, dout}, 8'h5A);
    chk("t4_replay_ready", {30'b0, rdy}, 2'b00);
    step(); #1;
    chk("t4_cleared", {31'b0, vo}, 0);
    // producer-side error blocks accept and counting
    eb = 1'b1; valid = 2'b11; data = {8'h77, 8'h77}; #1;
    chk("t5_ready", {30'b0, rdy}, 2'b00);
    chk("t5_error_o", {31'b0, err}, 0);
    step(); #1;
    chk("t5_no_accept", {31'b0, vo}, 0);
    chk("t5_cnt", {24'b0, cnt}, 5);
    eb = 1'b0; valid = 2'b00;
    step();
    // pass-through mode
    en = 1'b0; valid = 2'b10; data = {8'h99, 8'h3C}; #1;
    chk("t6_error_o", {31'b0, err}, 0);
    step(); #1;
    chk("t6_no_transfer", {31'b0, vo}, 0);
    valid = 2'b01; #1;
    chk("t6_ready", {30'b0, rdy}, 2'b01);
    step(); valid = 2'b00; #1;
    chk("t6_data_o", {24'b0, dout}, 8'h3C);
    step();
    // counter saturation and clear
    en = 1'b1; valid = 2'b11; data = {8'hFF, 8'h00};
    for (int i = 0; i < 300; i++) step();
    #1;
    chk("t7_saturated", {24'b0, cnt}, 255);
    clr = 1'b1;
    step(); clr = 1'b0; #1;
    chk("t7_cleared", {24'b0, cnt}, 0);
    valid = 2'b00;
    step();
    // asynchronous reset mid-transaction
    rdy_in = 1'b0; valid = 2'b11; data = {8'h12, 8'h12};
    step(); valid = 2'b00; #1;
    chk("t8_held", {31'b0, vo}, 1);
    rst_n = 1'b0; #1;
    chk("t8_async_reset", {31'b0, vo}, 0);
    step(); rst_n = 1'b1; rdy_in = 1'b1;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
